// File: rtl/flow_type_result_collector_if.sv
// Verdict, lookup and counter bus of the flow type result collector.
// master drives verdicts/lookups/clear; slave is the collector.
interface flow_type_result_collector_if #(
    parameter int FLOW_ID_W = 8,
    parameter int TYPE_W    = 3,
    parameter int CNT_W     = 16
);
    logic [FLOW_ID_W+TYPE_W-1:0]     i_flow_id_type;
    logic                            i_flow_id_type_valid;
    logic                            i_clear;
    logic                            i_rd_req;
    logic [FLOW_ID_W-1:0]            i_rd_flow_id;
    logic                            o_rd_valid;
    logic                            o_rd_hit;
    logic [TYPE_W-1:0]               o_rd_type;
    logic                            o_ready;
    logic [(2**TYPE_W)*CNT_W-1:0]    o_type_cnt;
    logic [CNT_W-1:0]                o_drop_cnt;

    modport master (
        output i_flow_id_type, i_flow_id_type_valid, i_clear, i_rd_req, i_rd_flow_id,
        input  o_rd_valid, o_rd_hit, o_rd_type, o_ready, o_type_cnt, o_drop_cnt
    );
    modport slave (
        input  i_flow_id_type, i_flow_id_type_valid, i_clear, i_rd_req, i_rd_flow_id,
        output o_rd_valid, o_rd_hit, o_rd_type, o_ready, o_type_cnt, o_drop_cnt
    );
endinterface

// File: rtl/flow_type_result_collector.sv
// Per-flow verdict table with saturating per-type/drop counters and 1-cycle lookups.
// Optional FLOW_RESULT_DUP_CHECK_EN: keep the first type of a valid entry, reject conflicting verdicts.
module flow_type_result_collector #(
    parameter int FLOW_ID_W = 8,
    parameter int TYPE_W    = 3,
    parameter int CNT_W     = 16
) (
    input  logic i_clk,
    input  logic i_rst,
    flow_type_result_collector_if.slave bus
);
    localparam int DEPTH  = 2**FLOW_ID_W;
    localparam int NTYPES = 2**TYPE_W;

    typedef enum logic [1:0] {S_INIT, S_IDLE, S_CLEAR} state_t;

    state_t               state_q;
    logic [FLOW_ID_W-1:0] sweep_addr_q;
    logic                 ready_q;

    // Entry layout: {valid, type}
    logic [TYPE_W:0] table_mem [DEPTH];

    logic [FLOW_ID_W-1:0] vd_id;
    logic [TYPE_W-1:0]    vd_type;
    logic                 clear_acc, dup_reject, vd_accept, vd_drop;

    assign vd_id   = bus.i_flow_id_type[FLOW_ID_W+TYPE_W-1:TYPE_W];
    assign vd_type = bus.i_flow_id_type[TYPE_W-1:0];

    always_comb begin
        clear_acc = ready_q && bus.i_clear;
`ifdef FLOW_RESULT_DUP_CHECK_EN
        dup_reject = table_mem[vd_id][TYPE_W] && (table_mem[vd_id][TYPE_W-1:0] != vd_type);
`else
        dup_reject = 1'b0;
`endif
        // A verdict colliding with an accepted clear is dropped, never written
        vd_accept = bus.i_flow_id_type_valid && ready_q && !clear_acc && !dup_reject;
        vd_drop   = bus.i_flow_id_type_valid && !vd_accept;
    end

    logic [NTYPES-1:0][CNT_W-1:0] type_cnt_q, type_cnt_d;
    logic [CNT_W-1:0]             drop_cnt_q, drop_cnt_d;

    always_comb begin
        type_cnt_d = type_cnt_q;
        drop_cnt_d = drop_cnt_q;
        if (clear_acc) begin
            type_cnt_d = '0;
            drop_cnt_d = '0;
        end
        if (vd_accept && type_cnt_d[vd_type] != '1)
            type_cnt_d[vd_type] = type_cnt_d[vd_type] + CNT_W'(1);
        if (vd_drop && drop_cnt_d != '1)
            drop_cnt_d = drop_cnt_d + CNT_W'(1);
    end

    // Single write port shared by the init/clear sweep and accepted verdicts
    logic                 tbl_we;
    logic [FLOW_ID_W-1:0] tbl_waddr;
    logic [TYPE_W:0]      tbl_wdata;

    always_comb begin
        tbl_we    = 1'b0;
        tbl_waddr = sweep_addr_q;
        tbl_wdata = '0;
        if (!ready_q) begin
            tbl_we = 1'b1;
        end else if (vd_accept) begin
            tbl_we    = 1'b1;
            tbl_waddr = vd_id;
            tbl_wdata = {1'b1, vd_type};
        end
    end

    always_ff @(posedge i_clk) begin
        if (tbl_we) table_mem[tbl_waddr] <= tbl_wdata;
    end

    // Registered read sees pre-write contents when a verdict hits the same id
    logic [TYPE_W:0] rd_entry_q, rd_entry_d;
    logic            rd_valid_q, rd_valid_d, rd_live_q, rd_live_d;

    always_comb begin
        rd_entry_d = table_mem[bus.i_rd_flow_id];
        rd_valid_d = bus.i_rd_req;
        rd_live_d  = bus.i_rd_req && ready_q;
    end

    always_ff @(posedge i_clk) begin
        rd_entry_q <= rd_entry_d;
        if (i_rst) begin
            rd_valid_q <= 1'b0;
            rd_live_q  <= 1'b0;
            type_cnt_q <= '0;
            drop_cnt_q <= '0;
        end else begin
            rd_valid_q <= rd_valid_d;
            rd_live_q  <= rd_live_d;
            type_cnt_q <= type_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= S_INIT;
            sweep_addr_q <= '0;
            ready_q      <= 1'b0;
        end else begin
            case (state_q)
                S_INIT, S_CLEAR: begin
                    sweep_addr_q <= sweep_addr_q + FLOW_ID_W'(1);
                    if (sweep_addr_q == '1) begin
                        state_q <= S_IDLE;
                        ready_q <= 1'b1;
                    end
                end
                S_IDLE: begin
                    if (bus.i_clear) begin
                        state_q <= S_CLEAR;
                        ready_q <= 1'b0;
                    end
                end
                default: begin
                    state_q      <= S_INIT;
                    sweep_addr_q <= '0;
                    ready_q      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_rd_valid = rd_valid_q;
    assign bus.o_rd_hit   = rd_live_q && rd_entry_q[TYPE_W];
    assign bus.o_rd_type  = (rd_live_q && rd_entry_q[TYPE_W]) ? rd_entry_q[TYPE_W-1:0] : '0;
    assign bus.o_ready    = ready_q;
    assign bus.o_type_cnt = type_cnt_q;
    assign bus.o_drop_cnt = drop_cnt_q;
endmodule
